// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the 5-stage CPU pipeline control blocks.
//   hz_state_t : halt-drain FSM states
//   fwd_sel_t  : EX operand source encoding (visible on fwd_*_sel)
//   OP_LW/OP_HLT : opcodes the decoder maps onto id_is_load / id_is_hlt
package cpu_pipe_pkg;

    localparam int unsigned OPCODE_W     = 4;
    localparam logic [OPCODE_W-1:0] OP_LW  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    // Cycles spent in DRAIN: HLT travels EX -> MEM -> WB and out of the pipe.
    localparam int unsigned DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_t;

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_MEM = 2'b01,
        SEL_WB  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hz_fwd_mux.sv
// Per-operand forwarding mux: picks MEM result over WB result over the RF value.
// Ports:
//   src_vld/src_reg/src_used  : EX-slot instruction and the source register it reads
//   mem_vld/mem_wen/mem_dst   : EX/MEM scoreboard slot
//   wb_vld/wb_wen/wb_dst      : MEM/WB scoreboard slot
//   rf_val/mem_val/wb_val     : candidate operand values
//   fwd_val/fwd_sel           : selected value and its source (fwd_sel_t encoding)
module hz_fwd_mux
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_AW  = 4,
    parameter bit          FWD_EN  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic              src_vld,
    input  logic [REG_AW-1:0] src_reg,
    input  logic              src_used,
    input  logic              mem_vld,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              wb_vld,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [DATA_W-1:0] rf_val,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [DATA_W-1:0] wb_val,
    output logic [DATA_W-1:0] fwd_val,
    output logic [1:0]        fwd_sel
);

    logic src_live;
    logic mem_hit;
    logic wb_hit;

    // Priority match; a hard-wired r0 source never takes a forwarded value.
    always_comb begin
        src_live = FWD_EN && src_vld && src_used && !(ZERO_R0 && (src_reg == '0));
        mem_hit  = src_live && mem_vld && mem_wen && (mem_dst == src_reg);
        wb_hit   = src_live && wb_vld && wb_wen && (wb_dst == src_reg);
        fwd_sel  = SEL_RF;
        fwd_val  = rf_val;
        if (mem_hit) begin
            fwd_sel = SEL_MEM;
            fwd_val = mem_val;
        end else if (wb_hit) begin
            fwd_sel = SEL_WB;
            fwd_val = wb_val;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and halt controller for the IF/ID/EX/MEM/WB pipeline.
// Keeps an EX/MEM/WB destination scoreboard, stalls on load-use (or any RAW when
// forwarding is off), squashes on taken redirects, forwards EX operands, and
// drains the pipe after HLT.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   id_valid, id_rs/id_rt, id_rs_used/id_rt_used, id_dst, id_wen,
//   id_is_load, id_is_hlt          : instruction currently in ID
//   ex_redirect                    : taken branch/jump resolved in EX
//   ex_a/ex_b, mem_result, wb_result : operand candidates
//   stall_if/stall_id/flush_if_id/bubble_ex : pipeline control (combinational)
//   fwd_a/fwd_b, fwd_a_sel/fwd_b_sel        : forwarded EX operands (combinational)
//   halted                         : registered, sticky until rst
module pipe_hazard_unit
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NREG    = 16,
    parameter bit          FWD_EN  = 1'b1,
    parameter bit          RF_BYP  = 1'b1,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [$clog2(NREG)-1:0] id_rs,
    input  logic [$clog2(NREG)-1:0] id_rt,
    input  logic                    id_rs_used,
    input  logic                    id_rt_used,
    input  logic [$clog2(NREG)-1:0] id_dst,
    input  logic                    id_wen,
    input  logic                    id_is_load,
    input  logic                    id_is_hlt,
    input  logic                    ex_redirect,
    input  logic [DATA_W-1:0]       ex_a,
    input  logic [DATA_W-1:0]       ex_b,
    input  logic [DATA_W-1:0]       mem_result,
    input  logic [DATA_W-1:0]       wb_result,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    flush_if_id,
    output logic                    bubble_ex,
    output logic [DATA_W-1:0]       fwd_a,
    output logic [DATA_W-1:0]       fwd_b,
    output logic [1:0]              fwd_a_sel,
    output logic [1:0]              fwd_b_sel,
    output logic                    halted
);

    localparam int unsigned REG_AW     = $clog2(NREG);
    localparam logic [1:0]  DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    // Scoreboard slots; MEM and WB only need what hazard/forward checks read.
    logic              ex_vld, ex_wen, ex_ld, ex_rs_u, ex_rt_u;
    logic [REG_AW-1:0] ex_dst, ex_rs, ex_rt;
    logic              mem_vld, mem_wen;
    logic [REG_AW-1:0] mem_dst;
    logic              wb_vld, wb_wen;
    logic [REG_AW-1:0] wb_dst;

    hz_state_t  state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    logic hz_ex, hz_mem, hz_wb, hazard, stall_run;

    function automatic logic slot_hit(input logic vld, input logic wen,
                                      input logic [REG_AW-1:0] dst,
                                      input logic [REG_AW-1:0] r, input logic used);
        return vld && wen && used && (dst == r) && !(ZERO_R0 && (r == '0));
    endfunction

    // Scoreboard shift; a bubble turns the incoming EX slot invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld  <= 1'b0;
            ex_wen  <= 1'b0;
            ex_ld   <= 1'b0;
            ex_rs_u <= 1'b0;
            ex_rt_u <= 1'b0;
            ex_dst  <= '0;
            ex_rs   <= '0;
            ex_rt   <= '0;
            mem_vld <= 1'b0;
            mem_wen <= 1'b0;
            mem_dst <= '0;
            wb_vld  <= 1'b0;
            wb_wen  <= 1'b0;
            wb_dst  <= '0;
        end else begin
            ex_vld  <= id_valid && !bubble_ex;
            ex_wen  <= id_wen;
            ex_ld   <= id_is_load;
            ex_rs_u <= id_rs_used;
            ex_rt_u <= id_rt_used;
            ex_dst  <= id_dst;
            ex_rs   <= id_rs;
            ex_rt   <= id_rt;
            mem_vld <= ex_vld;
            mem_wen <= ex_wen;
            mem_dst <= ex_dst;
            wb_vld  <= mem_vld;
            wb_wen  <= mem_wen;
            wb_dst  <= mem_dst;
        end
    end

    // Hazard detection against the ID sources.
    always_comb begin
        hz_ex  = slot_hit(ex_vld, ex_wen, ex_dst, id_rs, id_rs_used) ||
                 slot_hit(ex_vld, ex_wen, ex_dst, id_rt, id_rt_used);
        hz_mem = slot_hit(mem_vld, mem_wen, mem_dst, id_rs, id_rs_used) ||
                 slot_hit(mem_vld, mem_wen, mem_dst, id_rt, id_rt_used);
        hz_wb  = slot_hit(wb_vld, wb_wen, wb_dst, id_rs, id_rs_used) ||
                 slot_hit(wb_vld, wb_wen, wb_dst, id_rt, id_rt_used);
        if (FWD_EN) begin
            hazard = hz_ex && ex_ld;
        end else begin
            hazard = hz_ex || hz_mem || (!RF_BYP && hz_wb);
        end
        stall_run = id_valid && hazard && !ex_redirect && (state == RUN);
    end

    // Halt FSM: state register (halted registered alongside).
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            halted <= (state_nxt == HALTED);
        end
    end

    // Halt FSM: next state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (id_valid && id_is_hlt && !stall_run && !ex_redirect) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = HALTED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    // Halt FSM: pipeline control outputs; a redirect overrides a same-cycle stall.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        case (state)
            RUN: begin
                stall_if    = stall_run;
                stall_id    = stall_run;
                flush_if_id = ex_redirect;
                bubble_ex   = stall_run || ex_redirect;
            end
            DRAIN, HALTED: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: ;
        endcase
    end

    hz_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .FWD_EN (FWD_EN),
        .ZERO_R0(ZERO_R0)
    ) u_fwd_a (
        .src_vld (ex_vld),
        .src_reg (ex_rs),
        .src_used(ex_rs_u),
        .mem_vld (mem_vld),
        .mem_wen (mem_wen),
        .mem_dst (mem_dst),
        .wb_vld  (wb_vld),
        .wb_wen  (wb_wen),
        .wb_dst  (wb_dst),
        .rf_val  (ex_a),
        .mem_val (mem_result),
        .wb_val  (wb_result),
        .fwd_val (fwd_a),
        .fwd_sel (fwd_a_sel)
    );

    hz_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .FWD_EN (FWD_EN),
        .ZERO_R0(ZERO_R0)
    ) u_fwd_b (
        .src_vld (ex_vld),
        .src_reg (ex_rt),
        .src_used(ex_rt_u),
        .mem_vld (mem_vld),
        .mem_wen (mem_wen),
        .mem_dst (mem_dst),
        .wb_vld  (wb_vld),
        .wb_wen  (wb_wen),
        .wb_dst  (wb_dst),
        .rf_val  (ex_b),
        .mem_val (mem_result),
        .wb_val  (wb_result),
        .fwd_val (fwd_b),
        .fwd_sel (fwd_b_sel)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: a cycle-by-cycle vector table on the
// default configuration plus hand sequences for interlock length and halt drain.
module tb_pipe_hazard_unit;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 16;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned NVEC   = 24;

    localparam logic [DATA_W-1:0] EX_A  = 16'h1111;
    localparam logic [DATA_W-1:0] EX_B  = 16'h2222;
    localparam logic [DATA_W-1:0] MEM_R = 16'h3333;
    localparam logic [DATA_W-1:0] WB_R  = 16'h4444;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, id_is_hlt, ex_redirect;
    logic [REG_AW-1:0] id_rs, id_rt, id_dst;
    logic [DATA_W-1:0] ex_a, ex_b, mem_result, wb_result;

    // d0: default (forwarding on), d1: interlock with RF bypass, d2: interlock without.
    logic d0_stall_if, d0_stall_id, d0_flush, d0_bubble, d0_halted;
    logic d1_stall_if, d1_stall_id, d1_flush, d1_bubble, d1_halted;
    logic d2_stall_if, d2_stall_id, d2_flush, d2_bubble, d2_halted;
    logic [DATA_W-1:0] d0_fwd_a, d0_fwd_b, d1_fwd_a, d1_fwd_b, d2_fwd_a, d2_fwd_b;
    logic [1:0] d0_sel_a, d0_sel_b, d1_sel_a, d1_sel_b, d2_sel_a, d2_sel_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.DATA_W(DATA_W), .NREG(NREG), .FWD_EN(1'b1), .RF_BYP(1'b1), .ZERO_R0(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_wen(id_wen),
        .id_is_load(id_is_load), .id_is_hlt(id_is_hlt), .ex_redirect(ex_redirect),
        .ex_a(ex_a), .ex_b(ex_b), .mem_result(mem_result), .wb_result(wb_result),
        .stall_if(d0_stall_if), .stall_id(d0_stall_id), .flush_if_id(d0_flush),
        .bubble_ex(d0_bubble), .fwd_a(d0_fwd_a), .fwd_b(d0_fwd_b),
        .fwd_a_sel(d0_sel_a), .fwd_b_sel(d0_sel_b), .halted(d0_halted)
    );

    pipe_hazard_unit #(.DATA_W(DATA_W), .NREG(NREG), .FWD_EN(1'b0), .RF_BYP(1'b1), .ZERO_R0(1'b1)) dut_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_wen(id_wen),
        .id_is_load(id_is_load), .id_is_hlt(id_is_hlt), .ex_redirect(ex_redirect),
        .ex_a(ex_a), .ex_b(ex_b), .mem_result(mem_result), .wb_result(wb_result),
        .stall_if(d1_stall_if), .stall_id(d1_stall_id), .flush_if_id(d1_flush),
        .bubble_ex(d1_bubble), .fwd_a(d1_fwd_a), .fwd_b(d1_fwd_b),
        .fwd_a_sel(d1_sel_a), .fwd_b_sel(d1_sel_b), .halted(d1_halted)
    );

    pipe_hazard_unit #(.DATA_W(DATA_W), .NREG(NREG), .FWD_EN(1'b0), .RF_BYP(1'b0), .ZERO_R0(1'b1)) dut_nfb (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_wen(id_wen),
        .id_is_load(id_is_load), .id_is_hlt(id_is_hlt), .ex_redirect(ex_redirect),
        .ex_a(ex_a), .ex_b(ex_b), .mem_result(mem_result), .wb_result(wb_result),
        .stall_if(d2_stall_if), .stall_id(d2_stall_id), .flush_if_id(d2_flush),
        .bubble_ex(d2_bubble), .fwd_a(d2_fwd_a), .fwd_b(d2_fwd_b),
        .fwd_a_sel(d2_sel_a), .fwd_b_sel(d2_sel_b), .halted(d2_halted)
    );

    typedef struct {
        logic              v;
        logic [REG_AW-1:0] rs, rt;
        logic              rsu, rtu;
        logic [REG_AW-1:0] dst;
        logic              wen, ld, hlt, redir;
        logic              e_stall, e_flush, e_bub;
        logic [1:0]        e_sa, e_sb;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input int v, input int rs, input int rt, input int rsu,
                                input int rtu, input int dst, input int wen, input int ld,
                                input int hlt, input int redir, input int e_stall,
                                input int e_flush, input int e_bub, input int e_sa,
                                input int e_sb);
        vec_t r;
        r.v = 1'(v);        r.rs = REG_AW'(rs);   r.rt = REG_AW'(rt);
        r.rsu = 1'(rsu);    r.rtu = 1'(rtu);      r.dst = REG_AW'(dst);
        r.wen = 1'(wen);    r.ld = 1'(ld);        r.hlt = 1'(hlt);
        r.redir = 1'(redir);
        r.e_stall = 1'(e_stall); r.e_flush = 1'(e_flush); r.e_bub = 1'(e_bub);
        r.e_sa = 2'(e_sa);  r.e_sb = 2'(e_sb);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_exp(input logic [1:0] sel, input logic [DATA_W-1:0] rf);
        if (sel == 2'b01) return MEM_R;
        if (sel == 2'b10) return WB_R;
        return rf;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid    = t.v;   id_rs = t.rs;   id_rt = t.rt;
        id_rs_used  = t.rsu; id_rt_used = t.rtu;
        id_dst      = t.dst; id_wen = t.wen; id_is_load = t.ld;
        id_is_hlt   = t.hlt; ex_redirect = t.redir;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic check_reset_all();
        chk("rst_d0_stall_if", 16'(d0_stall_if), 16'd0);
        chk("rst_d0_stall_id", 16'(d0_stall_id), 16'd0);
        chk("rst_d0_flush",    16'(d0_flush),    16'd0);
        chk("rst_d0_bubble",   16'(d0_bubble),   16'd0);
        chk("rst_d0_halted",   16'(d0_halted),   16'd0);
        chk("rst_d0_sel_a",    16'(d0_sel_a),    16'd0);
        chk("rst_d0_sel_b",    16'(d0_sel_b),    16'd0);
        chk("rst_d0_fwd_a",    d0_fwd_a,         EX_A);
        chk("rst_d0_fwd_b",    d0_fwd_b,         EX_B);
        chk("rst_d1_ctl", 16'({d1_stall_if, d1_stall_id, d1_flush, d1_bubble, d1_halted}), 16'd0);
        chk("rst_d1_sel", 16'({d1_sel_a, d1_sel_b}), 16'd0);
        chk("rst_d1_fwd_a", d1_fwd_a, EX_A);
        chk("rst_d1_fwd_b", d1_fwd_b, EX_B);
        chk("rst_d2_ctl", 16'({d2_stall_if, d2_stall_id, d2_flush, d2_bubble, d2_halted}), 16'd0);
        chk("rst_d2_sel", 16'({d2_sel_a, d2_sel_b}), 16'd0);
        chk("rst_d2_fwd_a", d2_fwd_a, EX_A);
        chk("rst_d2_fwd_b", d2_fwd_b, EX_B);
    endtask

    initial begin
        int c1, c2;
        bit done1, done2;

        ex_a = EX_A; ex_b = EX_B; mem_result = MEM_R; wb_result = WB_R;

        // Each row is one cycle; scoreboard carries over between rows.
        //           v  rs rt rsu rtu dst wen ld hlt rd | stall flush bub sa sb
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // idle
        vecs[1]  = mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0); // LW r3
        vecs[2]  = mk(1, 1, 3, 1, 1, 4, 1, 0, 0, 0,  1, 0, 1, 0, 0); // ADD r4,r1,r3 load-use
        vecs[3]  = mk(1, 1, 3, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0, 0, 0); // retry, no stall
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2); // ADD in EX: B from WB
        vecs[5]  = mk(1, 5, 6, 1, 1, 2, 1, 0, 0, 0,  0, 0, 0, 0, 0); // ADD r2
        vecs[6]  = mk(1, 2, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0); // SUB r5,r2,r2
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1); // SUB in EX: A,B from MEM
        vecs[8]  = mk(1, 1, 1, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0); // ADD r0
        vecs[9]  = mk(1, 0, 0, 1, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0); // ADD r6,r0,r0
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // r0 never forwarded
        vecs[11] = mk(1, 1, 1, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0); // ADD r7
        vecs[12] = mk(1, 1, 1, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0); // ADD r7 again
        vecs[13] = mk(1, 7, 7, 1, 1, 9, 1, 0, 0, 0,  0, 0, 0, 0, 0); // ADD r9,r7,r7
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1); // MEM beats WB
        vecs[15] = mk(1, 1, 0, 1, 0,10, 1, 1, 0, 0,  0, 0, 0, 0, 0); // LW r10
        vecs[16] = mk(1, 2,10, 1, 0,11, 1, 0, 0, 0,  0, 0, 0, 0, 0); // rt=r10 unused: no stall
        vecs[17] = mk(1, 1, 0, 1, 0,12, 1, 1, 0, 0,  0, 0, 0, 0, 0); // LW r12; unused rt not fwd
        vecs[18] = mk(1,12,12, 1, 1,13, 1, 0, 0, 1,  0, 1, 1, 0, 0); // load-use + redirect
        vecs[19] = mk(1, 1, 0, 1, 0,14, 1, 1, 0, 0,  0, 0, 0, 0, 0); // LW r14
        vecs[20] = mk(0,14,14, 1, 1,15, 1, 0, 0, 0,  0, 0, 0, 0, 0); // id_valid=0: no stall
        vecs[21] = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0); // LW r0
        vecs[22] = mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0); // use r0 after LW r0
        vecs[23] = mk(1, 5, 6, 1, 1, 3, 1, 0, 0, 1,  0, 1, 1, 0, 0); // plain redirect

        // Reset state while rst is held.
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check_reset_all();
        next_cycle();
        rst = 1'b0;

        // Table on the default configuration.
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_stall_if", i), 16'(d0_stall_if), 16'(vecs[i].e_stall));
            chk($sformatf("v%0d_stall_id", i), 16'(d0_stall_id), 16'(vecs[i].e_stall));
            chk($sformatf("v%0d_flush", i),    16'(d0_flush),    16'(vecs[i].e_flush));
            chk($sformatf("v%0d_bubble", i),   16'(d0_bubble),   16'(vecs[i].e_bub));
            chk($sformatf("v%0d_sel_a", i),    16'(d0_sel_a),    16'(vecs[i].e_sa));
            chk($sformatf("v%0d_sel_b", i),    16'(d0_sel_b),    16'(vecs[i].e_sb));
            chk($sformatf("v%0d_fwd_a", i),    d0_fwd_a,         fwd_exp(vecs[i].e_sa, EX_A));
            chk($sformatf("v%0d_fwd_b", i),    d0_fwd_b,         fwd_exp(vecs[i].e_sb, EX_B));
            chk($sformatf("v%0d_halted", i),   16'(d0_halted),   16'd0);
            next_cycle();
        end

        // Interlock length without forwarding: ADD r2 ; ADD r7,r2,r3.
        do_reset();
        drive(mk(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        drive(mk(1, 2, 3, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("raw_d0_no_stall", 16'(d0_stall_id), 16'd0);
        chk("raw_d1_bubble",   16'(d1_bubble),   16'd1);
        chk("raw_d1_sel_a",    16'(d1_sel_a),    16'd0);
        c1 = 0; c2 = 0; done1 = 1'b0; done2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            if (!done1) begin
                if (d1_stall_id) c1++;
                else done1 = 1'b1;
            end
            if (!done2) begin
                if (d2_stall_id) c2++;
                else done2 = 1'b1;
            end
            next_cycle();
        end
        chk("raw_stall_cycles_rfbyp",   16'(c1), 16'd2);
        chk("raw_stall_cycles_norfbyp", 16'(c2), 16'd3);

        // HLT drain: 3 DRAIN cycles, halted from cycle 4, redirect ignored, rst clears.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("hlt_c0_stall_if", 16'(d0_stall_if), 16'd0);
        chk("hlt_c0_halted",   16'(d0_halted),   16'd0);
        next_cycle();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_stall_if", k), 16'(d0_stall_if), 16'd1);
            chk($sformatf("drain%0d_stall_id", k), 16'(d0_stall_id), 16'd1);
            chk($sformatf("drain%0d_bubble", k),   16'(d0_bubble),   16'd1);
            chk($sformatf("drain%0d_halted", k),   16'(d0_halted),   16'd0);
            next_cycle();
        end
        ex_redirect = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_halted", k),   16'(d0_halted),   16'd1);
            chk($sformatf("halt%0d_stall_if", k), 16'(d0_stall_if), 16'd1);
            chk($sformatf("halt%0d_bubble", k),   16'(d0_bubble),   16'd1);
            chk($sformatf("halt%0d_flush", k),    16'(d0_flush),    16'd0);
            next_cycle();
        end
        ex_redirect = 1'b0;
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("halt_rst_halted",   16'(d0_halted),   16'd0);
        chk("halt_rst_stall_if", 16'(d0_stall_if), 16'd0);
        next_cycle();
        rst = 1'b0;

        // HLT squashed by a same-cycle redirect stays in RUN.
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("hltsq_flush",    16'(d0_flush),    16'd1);
        chk("hltsq_stall_id", 16'(d0_stall_id), 16'd0);
        next_cycle();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (4) next_cycle();
        @(negedge clk);
        chk("hltsq_halted",   16'(d0_halted),   16'd0);
        chk("hltsq_stall_if", 16'(d0_stall_if), 16'd0);
        chk("hltsq_bubble",   16'(d0_bubble),   16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
